// File: rtl/idli_sqi_mem.sv
// SQI-mode serial SRAM responder: decodes instruction and 24-bit address nibbles,
// then streams sequential read data or accepts write data into a byte array.
module idli_sqi_mem #(
  parameter int ADDR_W = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cs_n,
  input  logic [3:0] i_sio,
  output logic [3:0] o_sio,
  output logic       o_sio_oe
);

  typedef enum logic [2:0] {
    INSTR,
    ADDR,
    DUMMY,
    READ,
    WRITE,
    IGNORE
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [7:0]          instr_q, instr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          wnib_q, wnib_d;
  logic [3:0]          sio_q, sio_d;
  logic                oe_q, oe_d;
  logic                mem_we;
  logic [7:0]          rd_byte;

  logic [7:0] mem_q [2**ADDR_W];

  assign rd_byte  = mem_q[addr_q];
  assign o_sio    = sio_q;
  assign o_sio_oe = oe_q;

  // phase_q tracks the nibble within the current data byte (0 = high, 1 = low).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    wnib_d  = wnib_q;
    sio_d   = sio_q;
    oe_d    = oe_q;
    mem_we  = 1'b0;

    if (i_cs_n) begin
      state_d = INSTR;
      cnt_d   = 4'd0;
      phase_d = 1'b0;
      sio_d   = 4'd0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        INSTR: begin
          instr_d = {instr_q[3:0], i_sio};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd1) state_d = ADDR;
        end
        ADDR: begin
          // Shifting into an ADDR_W-wide register drops address bits above ADDR_W.
          addr_d = {addr_q[ADDR_W-5:0], i_sio};
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            if (instr_q == 8'h03)      state_d = DUMMY;
            else if (instr_q == 8'h02) state_d = WRITE;
            else                       state_d = IGNORE;
          end
        end
        DUMMY: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd9) begin
            sio_d   = rd_byte[7:4];
            oe_d    = 1'b1;
            phase_d = 1'b1;
            state_d = READ;
          end
        end
        READ: begin
          if (phase_q) begin
            sio_d   = rd_byte[3:0];
            addr_d  = addr_q + 1'b1;
            phase_d = 1'b0;
          end else begin
            sio_d   = rd_byte[7:4];
            phase_d = 1'b1;
          end
        end
        WRITE: begin
          if (phase_q) begin
            mem_we  = 1'b1;
            addr_d  = addr_q + 1'b1;
            phase_d = 1'b0;
          end else begin
            wnib_d  = i_sio;
            phase_d = 1'b1;
          end
        end
        IGNORE: begin
          state_d = IGNORE;
        end
        default: begin
          state_d = INSTR;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= INSTR;
      cnt_q   <= 4'd0;
      phase_q <= 1'b0;
      instr_q <= 8'd0;
      addr_q  <= '0;
      wnib_q  <= 4'd0;
      sio_q   <= 4'd0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      wnib_q  <= wnib_d;
      sio_q   <= sio_d;
      oe_q    <= oe_d;
    end
  end

  // Storage is deliberately left out of reset so contents survive a core reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[addr_q] <= {wnib_q, i_sio};
  end

endmodule
